// File: rtl/lb_sched_pkg.sv
// Shared types, reg-word layout and pack helper for the loopback error-count scheduler.
package lb_sched_pkg;

  localparam int unsigned IDX_LSB   = 24;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned PAYLOAD_W = 24;
  localparam int unsigned REG_W     = IDX_LSB + IDX_W;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [PAYLOAD_W-1:0] payload;
  } reg_word_t;

  function automatic logic [REG_W-1:0] pack_reg_word(input logic [IDX_W-1:0]     idx,
                                                     input logic [PAYLOAD_W-1:0] payload);
    reg_word_t w;
    w.idx     = idx;
    w.payload = payload;
    return w;
  endfunction

endpackage

// File: rtl/lb_rr_arb.sv
// Combinational rotating-priority arbiter: the first requester at or above ptr (with wrap) wins.
module lb_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_c_o,
  output logic [PTR_W-1:0] idx_c_o,
  output logic             any_c_o
);

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  // Walk from the farthest offset down so the nearest requester from ptr overwrites last.
  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[wrap_add(ptr_i, unsigned'(k))]) begin
        idx_c_o = wrap_add(ptr_i, unsigned'(k));
        any_c_o = 1'b1;
      end
    end
    gnt_c_o[idx_c_o] = any_c_o;
  end

endmodule

// File: rtl/lb_err_cnt_sched.sv
// Round-robin scheduler sharing one 32-bit status word between NUM_SRC error-count sources.
// Define LB_SCHED_TOUT_EN to let an aged pending request cut a dwell short.
module lb_err_cnt_sched
  import lb_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned DWELL   = 256,
  parameter int unsigned TOUT    = 16
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ack,
  input  logic                        sw_hold,
  output logic [31:0]                 reg_data_out,
  output logic                        reg_fresh,
  output logic                        sched_state
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  if (NUM_SRC < 2 || NUM_SRC > 16 || DATA_W < 1 || DATA_W > PAYLOAD_W ||
      DWELL < 1 || TOUT < 1) begin : g_bad_param
    $error("lb_err_cnt_sched: parameter out of range");
  end

  sched_state_e        state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_SRC-1:0]  ack_q;
  logic [REG_W-1:0]    word_q;
  logic                fresh_q;

  logic [NUM_SRC-1:0]  gnt_c;
  logic [PTR_W-1:0]    idx_c;
  logic                any_c;
  logic [PTR_W-1:0]    ptr_nxt_c;
  logic [DATA_W-1:0]   payload_c;
  logic [NUM_SRC-1:0]  grant_c;
  logic                tout_hit_c;

  lb_rr_arb #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (src_req),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt_c),
    .idx_c_o (idx_c),
    .any_c_o (any_c)
  );

  assign payload_c = src_data[32'(idx_c)*DATA_W +: DATA_W];
  assign ptr_nxt_c = (idx_c == PTR_W'(NUM_SRC - 1)) ? '0 : idx_c + 1'b1;
  assign grant_c   = (state_q == SCAN) ? gnt_c : '0;

`ifdef LB_SCHED_TOUT_EN
  localparam int unsigned AGE_W = $clog2(TOUT + 1);

  logic [AGE_W-1:0] age_q [NUM_SRC];

  // Per-source pending age, saturating at TOUT and cleared by its own grant.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (grant_c[i]) begin
          age_q[i] <= '0;
        end else if (src_req[i] && (age_q[i] != AGE_W'(TOUT))) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tout_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (age_q[i] == AGE_W'(TOUT)) tout_hit_c = 1'b1;
    end
  end
`else
  assign tout_hit_c = 1'b0;
`endif

  // Scheduler FSM with registered grant pulse, status word and fresh strobe.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      word_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      ack_q   <= '0;
      fresh_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (any_c) begin
            ack_q   <= gnt_c;
            word_q  <= pack_reg_word(IDX_W'(idx_c), PAYLOAD_W'(payload_c));
            fresh_q <= 1'b1;
            ptr_q   <= ptr_nxt_c;
            cnt_q   <= CNT_W'(DWELL - 1);
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (((cnt_q == '0) || tout_hit_c) && !sw_hold) begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign src_ack      = ack_q;
  assign reg_data_out = word_q;
  assign reg_fresh    = fresh_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_lb_err_cnt_sched.sv
// Bench for lb_err_cnt_sched: three instances (DWELL 4, 1, 256) driven in lockstep and checked
// against a cycle-count reference model, plus directed scenarios; honours LB_SCHED_TOUT_EN.
module tb_lb_err_cnt_sched;

  localparam int NS   = 4;
  localparam int DW   = 24;
  localparam int TOUT = 16;
  localparam int NI   = 3;

  logic              clk;
  logic              rst;
  logic [NS-1:0]     src_req;
  logic [NS*DW-1:0]  src_data;
  logic              sw_hold;

  logic [NS-1:0]     ack   [NI];
  logic [31:0]       rdo   [NI];
  logic              fresh [NI];
  logic              st    [NI];

  int checks   = 0;
  int failures = 0;

  lb_err_cnt_sched #(.NUM_SRC(NS), .DATA_W(DW), .DWELL(4), .TOUT(TOUT)) u_d4 (
    .OPB_Clk(clk), .OPB_Rst(rst), .src_req(src_req), .src_data(src_data),
    .src_ack(ack[0]), .sw_hold(sw_hold), .reg_data_out(rdo[0]),
    .reg_fresh(fresh[0]), .sched_state(st[0]));

  lb_err_cnt_sched #(.NUM_SRC(NS), .DATA_W(DW), .DWELL(1), .TOUT(TOUT)) u_d1 (
    .OPB_Clk(clk), .OPB_Rst(rst), .src_req(src_req), .src_data(src_data),
    .src_ack(ack[1]), .sw_hold(sw_hold), .reg_data_out(rdo[1]),
    .reg_fresh(fresh[1]), .sched_state(st[1]));

  lb_err_cnt_sched #(.NUM_SRC(NS), .DATA_W(DW), .DWELL(256), .TOUT(TOUT)) u_d256 (
    .OPB_Clk(clk), .OPB_Rst(rst), .src_req(src_req), .src_data(src_data),
    .src_ack(ack[2]), .sw_hold(sw_hold), .reg_data_out(rdo[2]),
    .reg_fresh(fresh[2]), .sched_state(st[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a grant at edge g keeps the slot busy until edge g+DWELL (longer under
  // sw_hold); an idle slot serves the first requester found from the rotating pointer.
  int          dw     [NI];
  int          cyc;
  bit          m_hold [NI];
  int          m_gt   [NI];
  int          m_ptr  [NI];
  int          m_age  [NI][NS];
  logic [NS-1:0] e_ack  [NI];
  logic [31:0]   e_word [NI];
  logic          e_fresh[NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_hold[k] = 0; m_gt[k] = 0; m_ptr[k] = 0;
      e_ack[k] = '0; e_word[k] = '0; e_fresh[k] = 1'b0;
      for (int s = 0; s < NS; s++) m_age[k][s] = 0;
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int k = 0; k < NI; k++) begin
      int g;
      bit aged;
      g = -1;
      aged = 0;
`ifdef LB_SCHED_TOUT_EN
      for (int s = 0; s < NS; s++) if (m_age[k][s] >= TOUT) aged = 1;
`endif
      e_ack[k] = '0;
      e_fresh[k] = 1'b0;
      if (!m_hold[k]) begin
        for (int s = NS - 1; s >= 0; s--) begin
          int c;
          c = (m_ptr[k] + s) % NS;
          if (src_req[c]) g = c;
        end
        if (g >= 0) begin
          e_ack[k][g] = 1'b1;
          e_word[k]   = {8'(g), src_data[g*DW +: DW]};
          e_fresh[k]  = 1'b1;
          m_ptr[k]    = (g + 1) % NS;
          m_hold[k]   = 1;
          m_gt[k]     = cyc;
        end
      end else if (((cyc - m_gt[k]) >= dw[k] || aged) && !sw_hold) begin
        m_hold[k] = 0;
      end
      for (int s = 0; s < NS; s++) begin
        if (s == g) m_age[k][s] = 0;
        else if (src_req[s] && m_age[k][s] < TOUT) m_age[k][s]++;
      end
    end
  endtask

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, "_ack"},   k, 32'(ack[k]),   32'(e_ack[k]));
      check({tag, "_word"},  k, rdo[k],        e_word[k]);
      check({tag, "_fresh"}, k, 32'(fresh[k]), 32'(e_fresh[k]));
      check({tag, "_state"}, k, 32'(st[k]),    32'(m_hold[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all("model");
  endtask

  // Assert reset away from an edge, confirm the async clear, release one edge later.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) check("rst_state", k, 32'(st[k]), 32'(0));
  endtask

  function automatic int oh2idx(input logic [NS-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NS; i++) if (v[i]) r = i;
    return r;
  endfunction

  int gi [8];
  int gt [8];
  int n;
  int lat;
  int cnt;
  int exp_lat;

  initial begin
    dw[0] = 4; dw[1] = 1; dw[2] = 256;
    cyc = 0;
    src_req = '0; src_data = '0; sw_hold = 1'b0;
    rst = 1'b1;
    do_reset();

    // Single requester: one-cycle latency and the packed status word.
    src_req  = 4'b0100;
    src_data = {NS*DW{1'b1}};
    src_data[2*DW +: DW] = 24'h000ABC;
    step();
    for (int k = 0; k < NI; k++) begin
      check("t2_ack",   k, 32'(ack[k]),   32'h4);
      check("t2_word",  k, rdo[k],        32'h0200_0ABC);
      check("t2_fresh", k, 32'(fresh[k]), 32'h1);
    end
    // Reset while the grant pulse and HOLD are live.
    do_reset();

    // Everyone requesting on the DWELL=4 instance.
    src_req = 4'hF;
    src_data = {$urandom, $urandom, $urandom};
    n = 0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      step();
      if (ack[0] != '0) begin gi[n] = oh2idx(ack[0]); gt[n] = c; n++; end
    end
    check("t3_grants", 0, 32'(n), 32'(5));
    for (int i = 0; i < n; i++) begin
      check("t3_order", i, 32'(gi[i]), 32'(i % NS));
`ifndef LB_SCHED_TOUT_EN
      if (i > 0) check("t3_gap", i, 32'(gt[i] - gt[i-1]), 32'(5));
`endif
    end

    // Software freeze holds every instance in HOLD; release grants two edges later.
    do_reset();
    src_req = 4'b0001;
    step();
    src_req = 4'b0010;
    sw_hold = 1'b1;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      for (int k = 0; k < NI; k++) if (ack[k] != '0) cnt++;
    end
    check("t4_frozen_acks", 0, 32'(cnt), 32'(0));
    sw_hold = 1'b0;
    lat = -1;
    for (int c = 1; c <= 5 && lat < 0; c++) begin
      step();
      if (ack[0][1]) lat = c;
    end
    check("t4_release_lat", 0, 32'(lat), 32'(2));

    // DWELL=1: two steady requesters alternate every two cycles with pointer wrap.
    do_reset();
    src_req = 4'b1010;
    n = 0;
    for (int c = 1; c <= 30 && n < 6; c++) begin
      step();
      if (ack[1] != '0) begin gi[n] = oh2idx(ack[1]); gt[n] = c; n++; end
    end
    check("t5_grants", 1, 32'(n), 32'(6));
    for (int i = 0; i < n; i++) begin
      check("t5_order", i, 32'(gi[i]), (i % 2 == 0) ? 32'(1) : 32'(3));
      if (i > 0) check("t5_gap", i, 32'(gt[i] - gt[i-1]), 32'(2));
    end

    // Late requester on the DWELL=256 instance: timeout cuts the dwell when enabled.
    do_reset();
    src_req = 4'b0001;
    step();
    check("t6_grant0", 2, 32'(ack[2]), 32'h1);
    src_req = 4'b0010;
    lat = -1;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      step();
      if (ack[2][1]) lat = c;
    end
`ifdef LB_SCHED_TOUT_EN
    exp_lat = 18;
`else
    exp_lat = 257;
`endif
    check("t6_latency", 2, 32'(lat), 32'(exp_lat));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      src_req  = NS'($urandom);
      if ($urandom_range(0, 3) == 0) src_data = {$urandom, $urandom, $urandom};
      sw_hold  = ($urandom_range(0, 15) == 0);
      step();
      if (c == 300) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
